// File: rtl/sdpb_sim.sv
// Simple-dual-port RAM with independent port widths: port A writes, port B reads.
// Both ports view one flat bit array; narrow lanes map little-endian into wide words.
module sdpb_sim #(
   parameter int ADDRESS_DEPTH_A = 8,
   parameter int DATA_WIDTH_A    = 32,
   parameter int ADDRESS_DEPTH_B = 16,
   parameter int DATA_WIDTH_B    = 16,
   parameter int READ_MODE       = 0,
   localparam int AW_A = $clog2(ADDRESS_DEPTH_A),
   localparam int AW_B = $clog2(ADDRESS_DEPTH_B)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cea,
   input  logic [AW_A-1:0]         ada,
   input  logic [DATA_WIDTH_A-1:0] din,
   input  logic                    ceb,
   input  logic                    oce,
   input  logic [AW_B-1:0]         adb,
   output logic [DATA_WIDTH_B-1:0] dout
);

   localparam int TOTAL = ADDRESS_DEPTH_A * DATA_WIDTH_A;
   localparam int NW    = (DATA_WIDTH_A < DATA_WIDTH_B) ? DATA_WIDTH_A : DATA_WIDTH_B;
   localparam int RA    = DATA_WIDTH_A / NW;
   localparam int RB    = DATA_WIDTH_B / NW;
   localparam int RATIO = RA * RB;
   localparam int ND    = TOTAL / NW;
   localparam int IW    = (ND > 1) ? $clog2(ND) : 1;
   localparam int LRA   = $clog2(RA);
   localparam int LRB   = $clog2(RB);

   generate
      if ((TOTAL != ADDRESS_DEPTH_B * DATA_WIDTH_B) ||
          ((DATA_WIDTH_A > DATA_WIDTH_B ? DATA_WIDTH_A % DATA_WIDTH_B
                                        : DATA_WIDTH_B % DATA_WIDTH_A) != 0) ||
          ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_cfg
         $fatal(1, "sdpb_sim: port sizes must match and width ratio must be a power of two");
      end
   endgenerate

   // Storage is held as narrow lanes; a wide access touches RA (or RB) adjacent lanes.
   logic [NW-1:0]           mem [2**IW];
   logic [IW-1:0]           wr_base;
   logic [IW-1:0]           rd_base;
   logic                    wr_ok;
   logic                    rd_ok;
   logic [DATA_WIDTH_B-1:0] rd_word;

   assign wr_base = IW'(ada) << LRA;
   assign rd_base = IW'(adb) << LRB;
   assign wr_ok   = ({1'b0, ada} < (AW_A + 1)'(ADDRESS_DEPTH_A));
   assign rd_ok   = ({1'b0, adb} < (AW_B + 1)'(ADDRESS_DEPTH_B));

   always_ff @(posedge clk) begin
      if (reset_n && cea && wr_ok) begin
         for (int l = 0; l < RA; l++) begin
            mem[wr_base | IW'(l)] <= din[l*NW +: NW];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RB; gi++) begin : g_rd_lane
         assign rd_word[gi*NW +: NW] = rd_ok ? mem[rd_base | IW'(gi)] : '0;
      end
   endgenerate

   // Reads sample the array before this edge's write lands, giving read-before-write.
   generate
      if (READ_MODE == 1) begin : g_pipe
         logic [DATA_WIDTH_B-1:0] rd_latch_reg;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               rd_latch_reg <= '0;
               dout         <= '0;
            end else begin
               if (ceb) rd_latch_reg <= rd_word;
               if (oce) dout         <= rd_latch_reg;
            end
         end
      end else begin : g_bypass
         logic oce_unused;
         assign oce_unused = oce;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               dout <= '0;
            end else if (ceb) begin
               dout <= rd_word;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sdpb_sim.sv
// Bench for sdpb_sim: bypass and pipeline instances share stimulus against a flat-bit-array
// model; a third instance covers the reversed width ratio.
module tb_sdpb_sim;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, cea, ceb, oce;
   logic [2:0]  ada;
   logic [3:0]  adb;
   logic [31:0] din;
   logic [15:0] dout0, dout1;

   logic        cea2, ceb2;
   logic [3:0]  ada2;
   logic [2:0]  adb2;
   logic [15:0] din2;
   logic [31:0] dout2;

   sdpb_sim #(.READ_MODE(0)) u_bypass (
      .clk(clk), .reset_n(reset_n), .cea(cea), .ada(ada), .din(din),
      .ceb(ceb), .oce(oce), .adb(adb), .dout(dout0)
   );

   sdpb_sim #(.READ_MODE(1)) u_pipe (
      .clk(clk), .reset_n(reset_n), .cea(cea), .ada(ada), .din(din),
      .ceb(ceb), .oce(oce), .adb(adb), .dout(dout1)
   );

   sdpb_sim #(.ADDRESS_DEPTH_A(16), .DATA_WIDTH_A(16), .ADDRESS_DEPTH_B(8),
              .DATA_WIDTH_B(32), .READ_MODE(0)) u_rev (
      .clk(clk), .reset_n(reset_n), .cea(cea2), .ada(ada2), .din(din2),
      .ceb(ceb2), .oce(1'b1), .adb(adb2), .dout(dout2)
   );

   // Reference: the storage as one 256-bit vector, plus expected outputs.
   logic [255:0] mem_m = '0;
   logic [15:0]  exp0 = '0, exp1 = '0, lat1 = '0;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // Apply the edge to the model using the inputs about to be sampled, then advance.
   task automatic step();
      logic [15:0] rd;
      rd = mem_m[int'(adb)*16 +: 16];
      if (!reset_n) begin
         exp0 = '0;
         exp1 = '0;
         lat1 = '0;
      end else begin
         if (ceb) exp0 = rd;
         if (oce) exp1 = lat1;
         if (ceb) lat1 = rd;
         if (cea) mem_m[int'(ada)*32 +: 32] = din;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] lit;
      reset_n = 1'b0; cea = 1'b0; ceb = 1'b0; oce = 1'b0;
      ada = '0; adb = '0; din = '0;
      cea2 = 1'b0; ceb2 = 1'b0; ada2 = '0; adb2 = '0; din2 = '0;
      step();
      step();
      chk("reset_dout0", 32'(dout0), 32'h0);
      chk("reset_dout1", 32'(dout1), 32'h0);
      reset_n = 1'b1;

      // Fill through the wide port, drain through the narrow port.
      cea = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ada = 3'(i);
         din = 32'hDEADBEEF ^ 32'(i);
         step();
      end
      cea = 1'b0;
      ceb = 1'b1; oce = 1'b1;
      for (int j = 0; j < 16; j++) begin
         adb = 4'(j);
         step();
         lit = j[0] ? 16'hDEAD : (16'hBEEF ^ 16'(j >> 1));
         chk("drain_lit", 32'(dout0), 32'(lit));
         chk("drain_model0", 32'(dout0), 32'(exp0));
         chk("drain_model1", 32'(dout1), 32'(exp1));
      end

      // Reset with a write attempt in flight.
      reset_n = 1'b0; cea = 1'b1; ada = 3'd0; din = 32'h0; adb = 4'd0;
      step();
      chk("rst1_dout0", 32'(dout0), 32'h0);
      chk("rst1_dout1", 32'(dout1), 32'h0);
      step();
      chk("rst2_dout0", 32'(dout0), 32'h0);
      chk("rst2_dout1", 32'(dout1), 32'h0);
      reset_n = 1'b1; cea = 1'b0;
      step();
      chk("post_rst_dout0", 32'(dout0), 32'hBEEF);
      chk("post_rst_dout1", 32'(dout1), 32'(exp1));
      step();
      chk("post_rst_pipe", 32'(dout1), 32'hBEEF);

      // Same-edge write and read of word 0.
      cea = 1'b1; ada = 3'd0; din = 32'h12345678; adb = 4'd0;
      step();
      chk("collide_old", 32'(dout0), 32'hBEEF);
      cea = 1'b0;
      step();
      chk("collide_lo", 32'(dout0), 32'h5678);
      adb = 4'd1;
      step();
      chk("collide_hi", 32'(dout0), 32'h1234);

      // Enables low: output holds, memory untouched.
      ceb = 1'b0; adb = 4'd5;
      step();
      chk("ceb_hold", 32'(dout0), 32'h1234);
      ada = 3'd3; din = $urandom;
      step();
      chk("ceb_hold2", 32'(dout0), 32'h1234);
      ceb = 1'b1; adb = 4'd6;
      step();
      chk("cea_off_read", 32'(dout0), 32'hBEEC);
      chk("pipe_stage1", 32'(dout1), 32'(exp1));
      adb = 4'd0;
      step();
      chk("pipe_beec", 32'(dout1), 32'hBEEC);
      oce = 1'b0; adb = 4'd1;
      step();
      chk("oce_hold1", 32'(dout1), 32'hBEEC);
      step();
      chk("oce_hold2", 32'(dout1), 32'hBEEC);

      // Randomized traffic against the model, with occasional resets.
      for (int k = 0; k < 300; k++) begin
         reset_n = ($urandom_range(0, 15) != 0);
         cea = 1'($urandom);
         ceb = 1'($urandom);
         oce = 1'($urandom);
         ada = 3'($urandom);
         adb = 4'($urandom);
         din = $urandom;
         step();
         chk("rand_dout0", 32'(dout0), 32'(exp0));
         chk("rand_dout1", 32'(dout1), 32'(exp1));
      end
      reset_n = 1'b1; cea = 1'b0; ceb = 1'b0; oce = 1'b0;

      // Reverse ratio: two narrow writes read back as one wide word.
      cea2 = 1'b1; ada2 = 4'd4; din2 = 16'hAAAA;
      step();
      ada2 = 4'd5; din2 = 16'h5555;
      step();
      cea2 = 1'b0; ceb2 = 1'b1; adb2 = 3'd2;
      step();
      chk("reverse_ratio", dout2, 32'h5555AAAA);
      cea2 = 1'b1; ada2 = 4'd1; din2 = 16'h0F0F;
      step();
      ada2 = 4'd0; din2 = 16'hC3C3;
      step();
      cea2 = 1'b0; adb2 = 3'd0;
      step();
      chk("reverse_ratio_w0", dout2, 32'h0F0FC3C3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
